// File: rtl/lbist_controller_mc.sv
// lbist_controller_mc: multi-CUT logic-BIST sequencer with cut mask, single-seed mode, watchdog and per-cut error flags.
module lbist_controller_mc #(
  parameter int NUM_CUTS = 2,
  parameter int SEED_BITS = 32,
  parameter int SIGNATURE_BITS = 32,
  parameter int NUM_SEEDS = 8,
  parameter int MAX_OUTPUTS_TO_HASH = 32,
  parameter int MISR_MSG_BITS = $clog2(MAX_OUTPUTS_TO_HASH),
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [NUM_SEEDS*SEED_BITS-1:0] SEEDS = '0,
  parameter logic [NUM_CUTS*NUM_SEEDS*SIGNATURE_BITS-1:0] SIGNATURES = '0,
  parameter int IDX_BITS = $clog2(NUM_SEEDS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               lbist_req_val,
  output logic                               lbist_req_rdy,
  input  logic [NUM_CUTS+IDX_BITS:0]         lbist_req_msg,
  output logic                               lbist_resp_val,
  input  logic                               lbist_resp_rdy,
  output logic [NUM_CUTS*NUM_SEEDS-1:0]      lbist_resp_msg,
  output logic [NUM_CUTS-1:0]                lbist_resp_err,
  output logic [NUM_CUTS-1:0]                lfsr_resp_val,
  output logic [SEED_BITS-1:0]               lfsr_resp_msg,
  input  logic [NUM_CUTS-1:0]                lfsr_resp_rdy,
  output logic [NUM_CUTS-1:0]                misr_req_val,
  output logic [MISR_MSG_BITS:0]             misr_req_msg,
  input  logic [NUM_CUTS-1:0]                misr_req_rdy,
  input  logic [NUM_CUTS-1:0]                misr_resp_val,
  input  logic [NUM_CUTS*SIGNATURE_BITS-1:0] misr_resp_msg,
  output logic [NUM_CUTS-1:0]                misr_resp_rdy,
  output logic [NUM_CUTS-1:0]                lfsr_cut_reset
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMP, DONE} state_t;
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int NP = NUM_CUTS * NUM_SEEDS;
  state_t state_q, state_d;
  logic [NUM_CUTS-1:0] mask_q, mask_d, lacc_q, lacc_d, macc_q, macc_d, cap_q, cap_d, err_q, err_d;
  logic single_q, single_d;
  logic [IDX_BITS-1:0] cnt_q, cnt_d;
  logic [WD_BITS-1:0] wd_q, wd_d;
  logic [NP-1:0] pass_q, pass_d;
  logic [NUM_CUTS-1:0] req_mask, sig_fire;
  logic req_single, timeout, run;
  logic [IDX_BITS-1:0] req_idx, idx_clamp;
  assign {req_mask, req_single, req_idx} = lbist_req_msg;
  assign run = !reset;
  // Outputs decode only registered state, so no rdy/val input reaches an output combinationally.
  assign lbist_req_rdy = run && state_q == IDLE;
  assign lbist_resp_val = run && state_q == DONE;
  assign lbist_resp_msg = run ? pass_q : '0;
  assign lbist_resp_err = run ? err_q : '0;
  assign lfsr_resp_val = (run && state_q == ISSUE) ? mask_q & ~lacc_q : '0;
  assign misr_req_val = (run && state_q == ISSUE) ? mask_q & ~macc_q : '0;
  assign lfsr_resp_msg = (run && state_q == ISSUE) ? SEEDS[int'(cnt_q)*SEED_BITS +: SEED_BITS] : '0;
  assign misr_req_msg = (run && state_q == ISSUE) ? (MISR_MSG_BITS+1)'(MAX_OUTPUTS_TO_HASH) : '0;
  assign misr_resp_rdy = (run && state_q == WAIT) ? mask_q & ~cap_q : '0;
  assign lfsr_cut_reset = (run && state_q == COMP) ? mask_q : '0;
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    single_d = single_q;
    cnt_d = cnt_q;
    lacc_d = lacc_q;
    macc_d = macc_q;
    cap_d = cap_q;
    err_d = err_q;
    wd_d = wd_q;
    pass_d = pass_q;
    sig_fire = misr_resp_val & misr_resp_rdy;
    timeout = wd_q == WD_BITS'(TIMEOUT_CYCLES - 1);
    idx_clamp = ({1'b0, req_idx} > (IDX_BITS+1)'(NUM_SEEDS - 1)) ? IDX_BITS'(NUM_SEEDS - 1) : req_idx;
    case (state_q)
      IDLE: if (lbist_req_val) begin
        mask_d = req_mask == '0 ? '1 : req_mask;
        single_d = req_single;
        cnt_d = req_single ? idx_clamp : '0;
        pass_d = '0;
        err_d = '0;
        lacc_d = '0;
        macc_d = '0;
        cap_d = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        lacc_d = lacc_q | (lfsr_resp_val & lfsr_resp_rdy);
        macc_d = macc_q | (misr_req_val & misr_req_rdy);
        if ((lacc_q & macc_q & mask_q) == mask_q) begin
          lacc_d = '0;
          macc_d = '0;
          wd_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cap_d = cap_q | sig_fire;
        wd_d = wd_q + 1'b1;
        for (int c = 0; c < NUM_CUTS; c++)
          if (sig_fire[c])
            pass_d[c*NUM_SEEDS + int'(cnt_q)] = misr_resp_msg[c*SIGNATURE_BITS +: SIGNATURE_BITS] ==
              SIGNATURES[(c*NUM_SEEDS + int'(cnt_q))*SIGNATURE_BITS +: SIGNATURE_BITS];
        // Uncaptured cuts keep their cleared pass bit and get a sticky error.
        err_d = timeout ? err_q | (mask_q & ~cap_d) : err_q;
        state_d = ((cap_d & mask_q) == mask_q || timeout) ? COMP : WAIT;
      end
      COMP: begin
        cap_d = '0;
        state_d = (single_q || cnt_q == IDX_BITS'(NUM_SEEDS - 1)) ? DONE : ISSUE;
        cnt_d = state_d == ISSUE ? cnt_q + 1'b1 : cnt_q;
      end
      DONE: state_d = lbist_resp_rdy ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q <= '0;
      single_q <= 1'b0;
      cnt_q <= '0;
      lacc_q <= '0;
      macc_q <= '0;
      cap_q <= '0;
      err_q <= '0;
      wd_q <= '0;
      pass_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      single_q <= single_d;
      cnt_q <= cnt_d;
      lacc_q <= lacc_d;
      macc_q <= macc_d;
      cap_q <= cap_d;
      err_q <= err_d;
      wd_q <= wd_d;
      pass_q <= pass_d;
    end
  end
endmodule

// File: tb/tb_lbist_controller_mc.sv
// tb_lbist_controller_mc: scoreboard bench with behavioural LFSR/MISR wrappers for two cuts and four seeds.
module tb_lbist_controller_mc;
  localparam int NC = 2, NS = 4, SB = 32, DB = 32, TO = 16, IB = 2, MB = $clog2(32);
  function automatic logic [31:0] gold(input int c, input int s);
    return 32'hA000_0000 | 32'(c << 8) | 32'(s);
  endfunction
  function automatic logic [NC*NS*DB-1:0] mk_sigs();
    logic [NC*NS*DB-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++)
      for (int s = 0; s < NS; s++) v[(c*NS+s)*DB +: DB] = gold(c, s);
    return v;
  endfunction
  localparam logic [NS*SB-1:0] SEEDS = {32'h5EED_0003, 32'h5EED_0002, 32'h5EED_0001, 32'h5EED_0000};
  localparam logic [NC*NS*DB-1:0] SIGS = mk_sigs();

  logic clk = 0, reset = 1, lbist_req_val = 0, lbist_req_rdy, lbist_resp_val, lbist_resp_rdy = 1;
  logic [NC+IB:0] lbist_req_msg = '0;
  logic [NC*NS-1:0] lbist_resp_msg;
  logic [NC-1:0] lbist_resp_err, lfsr_resp_val, lfsr_resp_rdy, misr_req_val, misr_req_rdy;
  logic [NC-1:0] misr_resp_val, misr_resp_rdy, lfsr_cut_reset;
  logic [SB-1:0] lfsr_resp_msg;
  logic [MB:0] misr_req_msg;
  logic [NC*DB-1:0] misr_resp_msg;
  logic [56:0] outs_no_rdy;

  lbist_controller_mc #(.NUM_CUTS(NC), .SEED_BITS(SB), .SIGNATURE_BITS(DB), .NUM_SEEDS(NS),
    .MAX_OUTPUTS_TO_HASH(32), .TIMEOUT_CYCLES(TO), .SEEDS(SEEDS), .SIGNATURES(SIGS)) dut (
    .clk(clk), .reset(reset), .lbist_req_val(lbist_req_val), .lbist_req_rdy(lbist_req_rdy),
    .lbist_req_msg(lbist_req_msg), .lbist_resp_val(lbist_resp_val), .lbist_resp_rdy(lbist_resp_rdy),
    .lbist_resp_msg(lbist_resp_msg), .lbist_resp_err(lbist_resp_err), .lfsr_resp_val(lfsr_resp_val),
    .lfsr_resp_msg(lfsr_resp_msg), .lfsr_resp_rdy(lfsr_resp_rdy), .misr_req_val(misr_req_val),
    .misr_req_msg(misr_req_msg), .misr_req_rdy(misr_req_rdy), .misr_resp_val(misr_resp_val),
    .misr_resp_msg(misr_resp_msg), .misr_resp_rdy(misr_resp_rdy), .lfsr_cut_reset(lfsr_cut_reset));

  always #5 clk = ~clk;
  assign outs_no_rdy = {lbist_resp_val, lbist_resp_msg, lbist_resp_err, lfsr_resp_val, lfsr_resp_msg,
    misr_req_val, misr_req_msg, misr_resp_rdy, lfsr_cut_reset};

  typedef struct {
    logic [7:0] msg;
    logic [1:0] err;
    int r0, r1;
    logic [1:0] quiet;
    int lat, split;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int ldly[NC] = '{0, 0};
  int rdly = 1, bad_c = -1, bad_s = -1;
  logic [1:0] mute = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] m, input logic [1:0] e, input int r0, input int r1,
                              input logic [1:0] qt, input int lat, input int split);
    exp_t x;
    x.msg = m; x.err = e; x.r0 = r0; x.r1 = r1; x.quiet = qt; x.lat = lat; x.split = split;
    return x;
  endfunction

  // Per-cut LFSR/MISR wrapper models; the MISR hashes back the golden value of the seed it saw.
  initial begin
    int lw[NC], rw[NC], cs[NC];
    lw = '{0, 0}; rw = '{0, 0}; cs = '{0, 0};
    lfsr_resp_rdy = '0; misr_req_rdy = '1; misr_resp_val = '0; misr_resp_msg = '0;
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < NC; c++) begin
        if (lfsr_resp_val[c]) begin
          cs[c] = int'(lfsr_resp_msg[3:0]);
          lfsr_resp_rdy[c] = lw[c] >= ldly[c];
          lw[c]++;
        end else begin
          lfsr_resp_rdy[c] = 1'b0;
          lw[c] = 0;
        end
        if (misr_resp_rdy[c]) begin
          misr_resp_val[c] = !mute[c] && rw[c] >= rdly;
          misr_resp_msg[c*DB +: DB] = gold(c, cs[c]) ^ ((c == bad_c && cs[c] == bad_s) ? 32'h1 : 32'h0);
          rw[c]++;
        end else begin
          misr_resp_val[c] = 1'b0;
          rw[c] = 0;
        end
      end
    end
  end

  // Monitor: accumulates per-run activity and checks each result against the scoreboard head.
  initial begin
    int n, t0, split;
    int rst[NC], touch[NC];
    exp_t e;
    n = 0; t0 = 0; split = 0; rst = '{0, 0}; touch = '{0, 0};
    forever begin
      @(negedge clk);
      n++;
      if (reset || (lbist_req_val && lbist_req_rdy)) begin
        t0 = n; split = 0; rst = '{0, 0}; touch = '{0, 0};
      end else begin
        for (int c = 0; c < NC; c++) begin
          if (lfsr_cut_reset[c]) rst[c]++;
          if (lfsr_resp_val[c] | misr_req_val[c] | misr_resp_rdy[c] | lfsr_cut_reset[c]) touch[c]++;
        end
        if (lfsr_resp_val == 2'b10) split++;
        if (lbist_resp_val) begin
          chk("resp_expected", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("resp_msg", 64'(lbist_resp_msg), 64'(e.msg));
            chk("resp_err", 64'(lbist_resp_err), 64'(e.err));
            chk("cut_reset0", 64'(rst[0]), 64'(e.r0));
            chk("cut_reset1", 64'(rst[1]), 64'(e.r1));
            for (int c = 0; c < NC; c++) if (e.quiet[c]) chk("disabled_quiet", 64'(touch[c]), 64'd0);
            if (e.lat >= 0) chk("latency", 64'(n - t0), 64'(e.lat));
            if (e.split >= 0) chk("split_val", 64'(split), 64'(e.split));
          end
        end
      end
    end
  end

  task automatic run(input logic [1:0] mask, input logic single, input logic [1:0] idx, input exp_t e);
    bit seen;
    q.push_back(e);
    @(posedge clk); #1;
    lbist_req_val = 1; lbist_req_msg = {mask, single, idx};
    @(posedge clk); #1;
    lbist_req_val = 0;
    seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      seen = lbist_resp_val;
    end
    chk("run_done", 64'(seen), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 64'(outs_no_rdy), 64'd0);
    chk("reset_req_rdy", 64'(lbist_req_rdy), 64'd0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("post_reset_req_rdy", 64'(lbist_req_rdy), 64'd1);
    chk("post_reset_outs", 64'(outs_no_rdy), 64'd0);
    run(2'b11, 0, 0, mk(8'hFF, 2'b00, 4, 4, 2'b00, 21, 0));
    bad_c = 1; bad_s = 2;
    run(2'b11, 0, 0, mk(8'hBF, 2'b00, 4, 4, 2'b00, 21, -1));
    bad_c = -1; bad_s = -1;
    run(2'b01, 0, 0, mk(8'h0F, 2'b00, 4, 0, 2'b10, 21, -1));
    run(2'b11, 1, 3, mk(8'h88, 2'b00, 1, 1, 2'b00, 6, -1));
    run(2'b00, 1, 3, mk(8'h88, 2'b00, 1, 1, 2'b00, 6, -1));
    mute = 2'b01;
    run(2'b11, 0, 0, mk(8'hF0, 2'b01, 4, 4, 2'b00, 77, -1));
    mute = 2'b00;
    ldly[1] = 5;
    run(2'b11, 0, 0, mk(8'hFF, 2'b00, 4, 4, 2'b00, 41, 20));
    ldly[1] = 0;
    mute = 2'b11;
    @(posedge clk); #1;
    lbist_req_val = 1; lbist_req_msg = {2'b11, 1'b0, 2'b00};
    @(posedge clk); #1;
    lbist_req_val = 0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = misr_resp_rdy != 0;
    end
    chk("reach_wait", 64'(seen), 64'd1);
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    chk("mid_reset_outs", 64'(outs_no_rdy), 64'd0);
    chk("mid_reset_req_rdy", 64'(lbist_req_rdy), 64'd0);
    @(posedge clk); #1 reset = 0;
    mute = 2'b00;
    @(negedge clk);
    chk("after_reset_req_rdy", 64'(lbist_req_rdy), 64'd1);
    chk("after_reset_outs", 64'(outs_no_rdy), 64'd0);
    run(2'b10, 0, 0, mk(8'hF0, 2'b00, 0, 4, 2'b01, 21, -1));
    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got stuck expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end
endmodule
